// File: rtl/serial_pkg.sv
// Shared types and helpers for the single-wire serial link (transmitter now, receiver later).
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 and pulses bit_tick for the cycle the count wraps.
module serial_baud_gen
  import serial_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = !clear && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Byte-wide serial transmitter: start, DATA_W bits LSB-first, optional even parity, stop.
// Define SERIAL_TX_PARITY_EN to insert the parity bit after the data bits.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              line_d;
  logic              bit_tick;
  logic              accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign accept = tx_valid && tx_ready;

  // Held clear through IDLE so the start bit always begins at count 0.
  serial_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  // NOTE: every signal is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    line_d    = tx_line;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d   = START;
        shreg_d   = tx_data;
        bit_cnt_d = '0;
        line_d    = LINE_START;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = ^tx_data;
`endif
      end
      START: if (bit_tick) begin
        state_d = DATA;
        line_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
      DATA: if (bit_tick) begin
        if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
          line_d  = parity_q;
`else
          state_d = STOP;
          line_d  = LINE_IDLE;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          line_d    = shreg_q[0];
          shreg_d   = shreg_q >> 1;
        end
      end
      PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
        if (bit_tick) begin
          state_d = STOP;
          line_d  = LINE_IDLE;
        end
`else
        state_d = IDLE;
        line_d  = LINE_IDLE;
`endif
      end
      STOP: if (bit_tick) state_d = IDLE;
      default: begin
        state_d = IDLE;
        line_d  = LINE_IDLE;
      end
    endcase
  end

  // Outputs are flops fed from the next state, so the pin and handshake never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_line   <= LINE_IDLE;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_line   <= line_d;
      tx_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at DATA_W=8, CLK_DIV=4; follows SERIAL_TX_PARITY_EN if defined.
module tb_serial_tx;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FRAME  = (DATA_W + 3) * CLK_DIV;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FRAME  = (DATA_W + 2) * CLK_DIV;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_line;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  serial_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_line  (tx_line),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // seq holds the data bits in transmit order, first bit in seq[7].
  typedef struct {
    logic [7:0] data;
    logic [7:0] chg;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[5];

  // Waits (bounded) for tx_ready at a falling edge, then presents a byte.
  task automatic start_frame(input string name, input logic [7:0] data);
    int waited = 0;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({name, " ready"}, {7'd0, tx_ready}, 8'h01);
    tx_data  = data;
    tx_valid = 1'b1;
  endtask

  // Samples one frame from the first cycle after accept, then the IDLE cycle after it.
  task automatic run_frame(input string name, input logic [7:0] seq, input logic par,
                           input logic [7:0] chg, input bit hold, input int inj_idx,
                           input logic [7:0] inj_data);
    logic exp_line;
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      if (i == FRAME) begin
        check($sformatf("%s idle line", name), {7'd0, tx_line}, 8'h01);
        check($sformatf("%s idle ready", name), {7'd0, tx_ready}, 8'h01);
        check($sformatf("%s idle busy", name), {7'd0, busy}, 8'h00);
      end else begin
        if (i < CLK_DIV) exp_line = 1'b0;
        else if (i < (DATA_W + 1) * CLK_DIV) exp_line = seq[7 - (i / CLK_DIV - 1)];
        else if (PAR_EN && i < (DATA_W + 2) * CLK_DIV) exp_line = par;
        else exp_line = 1'b1;
        check($sformatf("%s line c%0d", name, i), {7'd0, tx_line}, {7'd0, exp_line});
        check($sformatf("%s busy c%0d", name, i), {7'd0, busy}, 8'h01);
        check($sformatf("%s ready c%0d", name, i), {7'd0, tx_ready}, 8'h00);
      end
      if (i == 0) begin
        tx_data = chg;
        if (!hold) tx_valid = 1'b0;
      end
      if (i == inj_idx) begin
        tx_valid = 1'b1;
        tx_data  = inj_data;
      end
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, chg: 8'h00, seq: 8'b1010_0101, par: 1'b0};
    vecs[1] = '{data: 8'h3C, chg: 8'hFF, seq: 8'b0011_1100, par: 1'b0};
    vecs[2] = '{data: 8'h07, chg: 8'h00, seq: 8'b1110_0000, par: 1'b1};
    vecs[3] = '{data: 8'h03, chg: 8'h00, seq: 8'b1100_0000, par: 1'b0};
    vecs[4] = '{data: 8'h00, chg: 8'hFF, seq: 8'b0000_0000, par: 1'b0};

    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset line", {7'd0, tx_line}, 8'h01);
    check("reset ready", {7'd0, tx_ready}, 8'h01);
    check("reset busy", {7'd0, busy}, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-reset line", {7'd0, tx_line}, 8'h01);
    check("post-reset ready", {7'd0, tx_ready}, 8'h01);
    check("post-reset busy", {7'd0, busy}, 8'h00);

    // Abort in the middle of DATA bit 1 of 0xA5 (a zero bit).
    start_frame("abort", 8'hA5);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort pre line", {7'd0, tx_line}, 8'h00);
    #1 reset_n = 1'b0;
    #1;
    check("abort async line", {7'd0, tx_line}, 8'h01);
    check("abort async busy", {7'd0, busy}, 8'h00);
    check("abort async ready", {7'd0, tx_ready}, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort idle line", {7'd0, tx_line}, 8'h01);

    for (int v = 0; v < 5; v++) begin
      start_frame($sformatf("vec%0d", v), vecs[v].data);
      run_frame($sformatf("vec%0d", v), vecs[v].seq, vecs[v].par, vecs[v].chg, 1'b0, -1, 8'h00);
    end

    // Back-to-back: second start must land exactly FRAME+1 cycles after the first accept.
    start_frame("b2b", 8'h01);
    run_frame("b2b0", 8'b1000_0000, 1'b1, 8'h80, 1'b1, -1, 8'h00);
    run_frame("b2b1", 8'b0000_0001, 1'b1, 8'h00, 1'b0, -1, 8'h00);

    // A byte offered mid-frame waits and is taken on the first IDLE cycle.
    start_frame("hold", 8'hA5);
    run_frame("hold_a5", 8'b1010_0101, 1'b0, 8'h00, 1'b0, 10, 8'h55);
    run_frame("hold_55", 8'b1010_1010, 1'b0, 8'h00, 1'b0, -1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Byte-wide asynchronous serial transmitter: the driving end of the single-wire serial link used on the project's I/O pins.
- Accepts a parallel byte over a valid/ready handshake.
- Shifts it out LSB-first as start bit, data, optional parity and stop bit, with a programmable bit period.
- Sits between core logic and an output pin; the far end samples the line with enable-gated flip-flops.

Parameters:
- DATA_W, 8, data bits per frame (5..8).
- CLK_DIV, 8, clk cycles per serial bit (>= 2).

Ports:
- clk  input  1  system clock, all state updated on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  byte to transmit; sampled only on handshake.
- tx_valid  input  1  tx_data holds a valid byte.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx_line  output  1  serial output; idle/stop level 1, start level 0.
- busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- Reset:
  - Asynchronous on reset_n low.
  - Reset values: tx_line=1, tx_ready=1, busy=0, state=IDLE, shift register=0, bit counter=0, divider counter=0.
  - Reset mid-frame aborts immediately; the line returns high with no partial stop bit.
- Handshake:
  - Accept occurs when tx_valid && tx_ready on a rising edge.
  - tx_data is copied into the shift register at accept; later changes on tx_data have no effect.
  - tx_ready is high only in IDLE and is registered; it is not combinationally dependent on tx_valid.
- States:
  - IDLE -> START on accept.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> PARITY (feature on) or STOP after DATA_W bit periods.
  - PARITY -> STOP after CLK_DIV cycles.
  - STOP -> IDLE after CLK_DIV cycles.
- Timing:
  - tx_line goes low in the first cycle after accept and is registered, with no glitches.
  - Every bit, including start and stop, is exactly CLK_DIV cycles.
  - Data goes out LSB first: bit i is driven during DATA period i.
- Divider: counts 0..CLK_DIV-1; the bit advances when the count wraps. The counter is cleared at accept so start-bit phase is deterministic.
- Back-to-back frames:
  - IDLE lasts at least one cycle, so the line idles high for at least 1 cycle between frames.
  - Effective stop time is CLK_DIV+1 cycles when tx_valid is held high.
  - Frame-to-frame period is (DATA_W+2)*CLK_DIV+1 cycles without parity, or (DATA_W+3)*CLK_DIV+1 with parity.
- busy: high from the cycle after accept through the last STOP cycle, low in IDLE.
- tx_valid while busy: ignored. The byte is held by the producer and accepted on the next IDLE cycle.

Optional Feature:
- SERIAL_TX_PARITY_EN defined:
  - PARITY state is inserted after the data bits.
  - The parity bit is even parity: the XOR of all DATA_W data bits, computed at accept.
- Not defined: no PARITY state and no parity logic; the frame is start + data + stop.

Decomposition:
- Package serial_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Line level constants: LINE_IDLE=1, LINE_START=0.
  - Width helper: divider counter width = $clog2(CLK_DIV).
- One natural sub-module: serial_baud_gen, the divider counter.
  - Inputs: clk, reset_n, clear.
  - Output: one-cycle bit_tick on wrap.
  - Reused by the future receiver.

Test Plan:
- Reset: hold reset_n=0, then release -> tx_line=1, tx_ready=1, busy=0; asserting reset_n=0 mid-DATA forces tx_line=1 in the same cycle, without waiting for a clock edge.
- CLK_DIV=4, no parity, send 0xA5 -> line after accept:
  - 0 (start) for 4 cycles.
  - Data 1,0,1,0,0,1,0,1, each 4 cycles.
  - 1 (stop) for 4 cycles.
  - Total 40 cycles, busy high throughout.
- Data stability: change tx_data from 0x3C to 0xFF the cycle after accept -> serial bits still 0,0,1,1,1,1,0,0.
- Back-to-back: hold tx_valid=1 with 0x01 then 0x80, CLK_DIV=4 -> second start bit begins exactly 41 cycles after the first accept; tx_ready pulses high 1 cycle between frames.
- SERIAL_TX_PARITY_EN:
  - Send 0x07 -> parity bit 1.
  - Send 0x03 -> parity bit 0.
  - Each frame is 44 cycles at CLK_DIV=4.
- Valid during busy: assert tx_valid with 0x55 mid-frame -> no corruption of the current frame; 0x55 is accepted on the first IDLE cycle.
